// File: rtl/rsid_alloc_table_if.sv
// Decode-side bundle for the RSID allocation table: allocation handshake,
// operand lookup ports, CDB retirement and flush.
interface rsid_alloc_table_if #(
  parameter int unsigned RSID_WIDTH = 4
);
  logic                  flush;
  logic                  alloc_req;
  logic                  alloc_ready;
  logic [RSID_WIDTH-1:0] alloc_rsid;
  logic                  alloc_wen;
  logic [4:0]            alloc_waddr;
  logic [4:0]            read_addr_1;
  logic [4:0]            read_addr_2;
  logic                  read_is_rsid_1;
  logic                  read_is_rsid_2;
  logic [RSID_WIDTH-1:0] read_rsid_1;
  logic [RSID_WIDTH-1:0] read_rsid_2;
  logic                  cdb_valid;
  logic [RSID_WIDTH-1:0] cdb_rsid;
  logic [RSID_WIDTH:0]   free_count;

  // Decode / issue logic side
  modport master (
    output flush, alloc_req, alloc_wen, alloc_waddr,
    output read_addr_1, read_addr_2, cdb_valid, cdb_rsid,
    input  alloc_ready, alloc_rsid, read_is_rsid_1, read_is_rsid_2,
    input  read_rsid_1, read_rsid_2, free_count
  );

  // Allocation table side
  modport slave (
    input  flush, alloc_req, alloc_wen, alloc_waddr,
    input  read_addr_1, read_addr_2, cdb_valid, cdb_rsid,
    output alloc_ready, alloc_rsid, read_is_rsid_1, read_is_rsid_2,
    output read_rsid_1, read_rsid_2, free_count
  );
endinterface

// File: rtl/rsid_alloc_table.sv
// RSID allocation table for the ID stage: circular free list of
// reservation-station tags plus a per-register {busy, tag} status table
// that tells the operand generator which sources are still in flight.
module rsid_alloc_table #(
  parameter int unsigned RSID_WIDTH = 4,
  parameter int unsigned REG_NUM    = 32
) (
  input logic              clk,
  input logic              rst,
  rsid_alloc_table_if.slave bus
);

  localparam int unsigned N = 2 ** RSID_WIDTH;
  localparam logic [RSID_WIDTH:0] FULL = (RSID_WIDTH + 1)'(N);

  typedef logic [RSID_WIDTH-1:0] rsid_t;

  // Free list storage and bookkeeping
  rsid_t               fifo [N];
  rsid_t               head;
  rsid_t               tail;
  logic [RSID_WIDTH:0] count;

  // Register status table
  logic [REG_NUM-1:0]  busy;
  rsid_t               tag [REG_NUM];

  // Qualified events for this cycle
  logic                fire;
  logic                rel;
  logic                wr;
  logic                clear;

  // Decode the cycle's events; a release into a full list is ignored entirely
  always_comb begin
    clear = rst || bus.flush;
    fire  = bus.alloc_req && (count != '0);
    rel   = bus.cdb_valid && (count != FULL);
    wr    = fire && bus.alloc_wen && (bus.alloc_waddr != '0);
  end

  // Free list: pop at head on fire, push released tag at tail
  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= FULL;
      for (int unsigned i = 0; i < N; i++) begin
        fifo[i] <= rsid_t'(i);
      end
    end else begin
      if (fire) begin
        head <= head + 1'b1;
      end
      if (rel) begin
        fifo[tail] <= bus.cdb_rsid;
        tail       <= tail + 1'b1;
      end
      case ({fire, rel})
        2'b10:   count <= count - 1'b1;
        2'b01:   count <= count + 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Status table: alloc write takes precedence over a same-cycle CDB clear
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      if (clear) begin
        busy[i] <= 1'b0;
        tag[i]  <= '0;
      end else if (wr && (bus.alloc_waddr == 5'(i))) begin
        busy[i] <= 1'b1;
        tag[i]  <= fifo[head];
      end else if (rel && busy[i] && (tag[i] == bus.cdb_rsid)) begin
        busy[i] <= 1'b0;
      end
    end
  end

  // Operand lookups see only registered state (no same-cycle bypass)
  always_comb begin
    bus.read_is_rsid_1 = busy[bus.read_addr_1];
    bus.read_is_rsid_2 = busy[bus.read_addr_2];
    bus.read_rsid_1    = busy[bus.read_addr_1] ? tag[bus.read_addr_1] : '0;
    bus.read_rsid_2    = busy[bus.read_addr_2] ? tag[bus.read_addr_2] : '0;
  end

  // Allocation status
  always_comb begin
    bus.alloc_ready = (count != '0);
    bus.alloc_rsid  = fifo[head];
    bus.free_count  = count;
  end

endmodule

// File: tb/tb_rsid_alloc_table.sv
// Self-checking bench for rsid_alloc_table: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_rsid_alloc_table;

  localparam int W = 4;
  localparam int N = 16;
  localparam int R = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsid_alloc_table_if #(.RSID_WIDTH(W)) bus ();

  rsid_alloc_table #(.RSID_WIDTH(W), .REG_NUM(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: free tags in FIFO order, per-register pending tag
  int fq [$];
  bit mb [R];
  int mt [R];

  function automatic void model_step();
    bit fire, rel;
    int g;
    if (rst || bus.flush) begin
      fq.delete();
      for (int i = 0; i < N; i++) fq.push_back(i);
      for (int r = 0; r < R; r++) begin mb[r] = 0; mt[r] = 0; end
      return;
    end
    fire = bus.alloc_req && (fq.size() != 0);
    rel  = bus.cdb_valid && (fq.size() != N);
    if (rel)
      for (int r = 0; r < R; r++)
        if (mb[r] && mt[r] == int'(bus.cdb_rsid)) mb[r] = 0;
    if (fire) begin
      g = fq.pop_front();
      if (bus.alloc_wen && bus.alloc_waddr != 0) begin
        mb[bus.alloc_waddr] = 1;
        mt[bus.alloc_waddr] = g;
      end
    end
    if (rel) fq.push_back(int'(bus.cdb_rsid));
  endfunction

  // Releasing into a full free list is a protocol violation by the driver
  always @(posedge clk) begin
    if (!rst && !bus.flush && bus.cdb_valid && bus.free_count == 5'd16) begin
      total++;
      $display("FAIL protocol: cdb release with free_count=%0d (must be < 16)", bus.free_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush       = 0;
    bus.alloc_req   = 0;
    bus.alloc_wen   = 0;
    bus.alloc_waddr = '0;
    bus.read_addr_1 = '0;
    bus.read_addr_2 = '0;
    bus.cdb_valid   = 0;
    bus.cdb_rsid    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic alloc(input int waddr, input bit wen);
    bus.alloc_req = 1; bus.alloc_wen = wen; bus.alloc_waddr = 5'(waddr);
    tick();
    bus.alloc_req = 0; bus.alloc_wen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.alloc_ready !== 1'b1) $display("FAIL reset_ready: got %0d want 1", bus.alloc_ready); else passed++;
    total++; if (bus.alloc_rsid !== 4'd0) $display("FAIL reset_rsid: got %0d want 0", bus.alloc_rsid); else passed++;
    total++; if (bus.free_count !== 5'd16) $display("FAIL reset_free: got %0d want 16", bus.free_count); else passed++;
    for (int k = 0; k < 4; k++) begin
      bus.read_addr_1 = 5'($urandom_range(0, 31));
      bus.read_addr_2 = 5'($urandom_range(0, 31));
      #1;
      total++;
      if (bus.read_is_rsid_1 !== 1'b0 || bus.read_rsid_1 !== 4'd0 ||
          bus.read_is_rsid_2 !== 1'b0 || bus.read_rsid_2 !== 4'd0)
        $display("FAIL reset_read: got is=%0d/%0d rsid=%0d/%0d want 0/0 0/0",
                 bus.read_is_rsid_1, bus.read_is_rsid_2, bus.read_rsid_1, bus.read_rsid_2);
      else passed++;
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int c = 0; c <= N; c++) begin
      bus.alloc_req = 1;
      #1;
      total++;
      if (c < N) begin
        if (bus.alloc_ready !== 1'b1 || int'(bus.alloc_rsid) != c || int'(bus.free_count) != N - c)
          $display("FAIL drain_%0d: got ready=%0d rsid=%0d free=%0d want 1 %0d %0d",
                   c, bus.alloc_ready, bus.alloc_rsid, bus.free_count, c, N - c);
        else passed++;
      end else begin
        if (bus.alloc_ready !== 1'b0 || bus.free_count !== 5'd0)
          $display("FAIL drain_empty: got ready=%0d free=%0d want 0 0", bus.alloc_ready, bus.free_count);
        else passed++;
      end
      tick();
    end
    bus.alloc_req = 0;
    #1;
    total++; if (bus.free_count !== 5'd0) $display("FAIL drain_hold: got free=%0d want 0", bus.free_count); else passed++;
  endtask

  task automatic test_pending_release();
    do_reset();
    alloc(5, 1);
    bus.read_addr_1 = 5'd5;
    #1;
    total++;
    if (bus.read_is_rsid_1 !== 1'b1 || bus.read_rsid_1 !== 4'd0)
      $display("FAIL pend_busy: got is=%0d rsid=%0d want 1 0", bus.read_is_rsid_1, bus.read_rsid_1);
    else passed++;
    bus.cdb_valid = 1; bus.cdb_rsid = 4'd0;
    tick();
    bus.cdb_valid = 0;
    #1;
    total++;
    if (bus.read_is_rsid_1 !== 1'b0 || bus.read_rsid_1 !== 4'd0 || bus.free_count !== 5'd16)
      $display("FAIL pend_release: got is=%0d rsid=%0d free=%0d want 0 0 16",
               bus.read_is_rsid_1, bus.read_rsid_1, bus.free_count);
    else passed++;
  endtask

  task automatic test_rename();
    do_reset();
    alloc(5, 1);
    alloc(5, 1);
    bus.read_addr_1 = 5'd5;
    #1;
    total++;
    if (bus.read_is_rsid_1 !== 1'b1 || bus.read_rsid_1 !== 4'd1)
      $display("FAIL rename_newest: got is=%0d rsid=%0d want 1 1", bus.read_is_rsid_1, bus.read_rsid_1);
    else passed++;
    bus.cdb_valid = 1; bus.cdb_rsid = 4'd0;
    tick();
    bus.cdb_valid = 0;
    #1;
    total++;
    if (bus.read_is_rsid_1 !== 1'b1 || bus.read_rsid_1 !== 4'd1)
      $display("FAIL rename_stale_cdb: got is=%0d rsid=%0d want 1 1", bus.read_is_rsid_1, bus.read_rsid_1);
    else passed++;
    bus.cdb_valid = 1; bus.cdb_rsid = 4'd1;
    tick();
    bus.cdb_valid = 0;
    #1;
    total++;
    if (bus.read_is_rsid_1 !== 1'b0 || bus.read_rsid_1 !== 4'd0 || bus.free_count !== 5'd16)
      $display("FAIL rename_idle: got is=%0d rsid=%0d free=%0d want 0 0 16",
               bus.read_is_rsid_1, bus.read_rsid_1, bus.free_count);
    else passed++;
  endtask

  task automatic test_zero_and_collision();
    do_reset();
    alloc(0, 1);
    bus.read_addr_1 = 5'd0;
    #1;
    total++;
    if (bus.free_count !== 5'd15 || bus.read_is_rsid_1 !== 1'b0 || bus.read_rsid_1 !== 4'd0)
      $display("FAIL zero_reg: got free=%0d is=%0d rsid=%0d want 15 0 0",
               bus.free_count, bus.read_is_rsid_1, bus.read_rsid_1);
    else passed++;
    alloc(7, 1);
    bus.read_addr_2 = 5'd7;
    #1;
    total++;
    if (bus.read_is_rsid_2 !== 1'b1 || bus.read_rsid_2 !== 4'd1)
      $display("FAIL collide_pre: got is=%0d rsid=%0d want 1 1", bus.read_is_rsid_2, bus.read_rsid_2);
    else passed++;
    bus.cdb_valid = 1; bus.cdb_rsid = 4'd1;
    alloc(7, 1);
    bus.cdb_valid = 0;
    #1;
    total++;
    if (bus.read_is_rsid_2 !== 1'b1 || bus.read_rsid_2 !== 4'd2 || bus.free_count !== 5'd14)
      $display("FAIL collide_alloc_wins: got is=%0d rsid=%0d free=%0d want 1 2 14",
               bus.read_is_rsid_2, bus.read_rsid_2, bus.free_count);
    else passed++;
  endtask

  task automatic test_release_when_empty();
    do_reset();
    for (int c = 0; c < N; c++) alloc(c % 3, 0);
    total++;
    if (bus.free_count !== 5'd0 || bus.alloc_ready !== 1'b0)
      $display("FAIL empty_state: got free=%0d ready=%0d want 0 0", bus.free_count, bus.alloc_ready);
    else passed++;
    bus.cdb_valid = 1; bus.cdb_rsid = 4'd9;
    alloc(3, 1);
    bus.cdb_valid = 0;
    bus.read_addr_1 = 5'd3;
    #1;
    total++;
    if (bus.free_count !== 5'd1 || bus.alloc_ready !== 1'b1 || bus.alloc_rsid !== 4'd9 || bus.read_is_rsid_1 !== 1'b0)
      $display("FAIL empty_refill: got free=%0d ready=%0d rsid=%0d is3=%0d want 1 1 9 0",
               bus.free_count, bus.alloc_ready, bus.alloc_rsid, bus.read_is_rsid_1);
    else passed++;
  endtask

  task automatic test_flush();
    int bad;
    do_reset();
    for (int r = 1; r <= 5; r++) alloc(r, 1);
    bus.read_addr_1 = 5'd3;
    #1;
    total++;
    if (bus.read_is_rsid_1 !== 1'b1 || bus.read_rsid_1 !== 4'd2 || bus.free_count !== 5'd11)
      $display("FAIL flush_pre: got is=%0d rsid=%0d free=%0d want 1 2 11",
               bus.read_is_rsid_1, bus.read_rsid_1, bus.free_count);
    else passed++;
    bus.flush = 1; bus.cdb_valid = 1; bus.cdb_rsid = 4'd2;
    alloc(6, 1);
    bus.flush = 0; bus.cdb_valid = 0;
    bad = 0;
    for (int r = 0; r < R; r++) begin
      bus.read_addr_1 = 5'(r);
      bus.read_addr_2 = 5'(R - 1 - r);
      #1;
      if (bus.read_is_rsid_1 !== 1'b0 || bus.read_rsid_1 !== 4'd0 || bus.read_is_rsid_2 !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL flush_table: got %0d busy lookups want 0", bad); else passed++;
    total++;
    if (bus.free_count !== 5'd16 || bus.alloc_ready !== 1'b1 || bus.alloc_rsid !== 4'd0)
      $display("FAIL flush_list: got free=%0d ready=%0d rsid=%0d want 16 1 0",
               bus.free_count, bus.alloc_ready, bus.alloc_rsid);
    else passed++;
  endtask

  task automatic test_random();
    bit isfree [N];
    int inflight [$];
    int bad_alloc, bad_read;
    do_reset();
    bad_alloc = 0; bad_read = 0;
    for (int c = 0; c < 600; c++) begin
      bus.read_addr_1 = 5'($urandom_range(0, 31));
      bus.read_addr_2 = 5'($urandom_range(0, 31));
      bus.alloc_req   = ($urandom_range(0, 9) < 6);
      bus.alloc_wen   = $urandom_range(0, 3) != 0;
      bus.alloc_waddr = 5'($urandom_range(0, 31));
      bus.flush       = ($urandom_range(0, 63) == 0);
      for (int t = 0; t < N; t++) isfree[t] = 0;
      foreach (fq[k]) isfree[fq[k]] = 1;
      inflight.delete();
      for (int t = 0; t < N; t++) if (!isfree[t]) inflight.push_back(t);
      bus.cdb_valid = (inflight.size() != 0) && ($urandom_range(0, 1) == 1);
      bus.cdb_rsid  = bus.cdb_valid ? 4'(inflight[$urandom_range(0, inflight.size() - 1)]) : 4'd0;
      #1;
      if (bus.alloc_ready !== (fq.size() != 0) || int'(bus.free_count) != fq.size() ||
          (fq.size() != 0 && int'(bus.alloc_rsid) != fq[0])) begin
        bad_alloc++;
        if (bad_alloc <= 3)
          $display("FAIL rand_alloc_c%0d: got ready=%0d rsid=%0d free=%0d want free=%0d head=%0d",
                   c, bus.alloc_ready, bus.alloc_rsid, bus.free_count, fq.size(),
                   fq.size() != 0 ? fq[0] : -1);
      end
      if (bus.read_is_rsid_1 !== mb[bus.read_addr_1] ||
          int'(bus.read_rsid_1) != (mb[bus.read_addr_1] ? mt[bus.read_addr_1] : 0) ||
          bus.read_is_rsid_2 !== mb[bus.read_addr_2] ||
          int'(bus.read_rsid_2) != (mb[bus.read_addr_2] ? mt[bus.read_addr_2] : 0)) begin
        bad_read++;
        if (bad_read <= 3)
          $display("FAIL rand_read_c%0d: got %0d:%0d/%0d %0d:%0d/%0d want %0d/%0d %0d/%0d", c,
                   bus.read_addr_1, bus.read_is_rsid_1, bus.read_rsid_1,
                   bus.read_addr_2, bus.read_is_rsid_2, bus.read_rsid_2,
                   mb[bus.read_addr_1], mt[bus.read_addr_1], mb[bus.read_addr_2], mt[bus.read_addr_2]);
      end
      tick();
    end
    idle();
    total++; if (bad_alloc != 0) $display("FAIL rand_alloc: got %0d bad cycles want 0", bad_alloc); else passed++;
    total++; if (bad_read != 0) $display("FAIL rand_read: got %0d bad cycles want 0", bad_read); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_drain();
    test_pending_release();
    test_rename();
    test_zero_and_collision();
    test_release_when_empty();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
